// File: rtl/uart_fifo.sv
// Bus front-end for the uart block: TX and RX byte FIFOs plus the two small FSMs
// that hand bytes to / take bytes from the UART with H-cycle handshakes.
module uart_fifo #(
   parameter int unsigned DEPTH_LOG2 = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] clkdiv,
   input  logic        bus_addr,
   input  logic        bus_re,
   input  logic        bus_we,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        irq,
   output logic        uart_we,
   output logic        uart_re,
   output logic [31:0] uart_so,
   input  logic [31:0] uart_si,
   input  logic        uart_wa
);

   localparam int unsigned Depth = 1 << DEPTH_LOG2;
   localparam int unsigned PtrW  = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {TxIdle, TxLoad, TxWait} tx_state_e;
   typedef enum logic       {RxIdle, RxAck}          rx_state_e;

   tx_state_e tx_state_q, tx_state_d;
   rx_state_e rx_state_q, rx_state_d;
   logic [17:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [17:0] hold;

   logic [7:0]      tx_mem [Depth];
   logic [7:0]      rx_mem [Depth];
   logic [PtrW-1:0] tx_wptr_q, tx_rptr_q, rx_wptr_q, rx_rptr_q;
   logic [7:0]      tx_byte_q;
   logic [31:0]     bus_rdata_q;
   logic            overrun_q;

   logic tx_full, tx_empty, rx_full, rx_empty;
   logic tx_push, tx_pop, rx_req, rx_push, rx_pop, ovr_set, ovr_clr;
   logic [31:0] status;

   assign hold = {1'b0, clkdiv[16:0]} + 18'd1;

   assign tx_empty = (tx_wptr_q == tx_rptr_q);
   assign tx_full  = (tx_wptr_q[PtrW-1] != tx_rptr_q[PtrW-1]) &&
                     (tx_wptr_q[PtrW-2:0] == tx_rptr_q[PtrW-2:0]);
   assign rx_empty = (rx_wptr_q == rx_rptr_q);
   assign rx_full  = (rx_wptr_q[PtrW-1] != rx_rptr_q[PtrW-1]) &&
                     (rx_wptr_q[PtrW-2:0] == rx_rptr_q[PtrW-2:0]);

   // Full/empty come from the registered pointers, so same-cycle push and pop never interact.
   assign tx_push = bus_we && !bus_addr && !tx_full;
   assign tx_pop  = (tx_state_q == TxIdle) && !tx_empty && !uart_wa;
   assign rx_req  = (rx_state_q == RxIdle) && (uart_si != 32'hFFFF_FFFF);
   assign rx_push = rx_req && !rx_full;
   assign rx_pop  = bus_re && !bus_addr && !rx_empty;
   assign ovr_set = rx_req && rx_full;
   assign ovr_clr = bus_we && bus_addr && bus_wdata[4];

   assign status    = {27'b0, overrun_q, rx_full, rx_empty, tx_empty, tx_full};
   assign bus_rdata = bus_rdata_q;
   assign uart_so   = {24'b0, tx_byte_q};
   assign irq       = !rx_empty || overrun_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_state_q <= TxIdle;
         rx_state_q <= RxIdle;
         tx_cnt_q   <= '0;
         rx_cnt_q   <= '0;
      end else begin
         tx_state_q <= tx_state_d;
         rx_state_q <= rx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         rx_cnt_q   <= rx_cnt_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      case (tx_state_q)
         TxIdle: if (tx_pop) begin
            tx_state_d = TxLoad;
            tx_cnt_d   = hold;
         end
         TxLoad: if (tx_cnt_q == 18'd1) tx_state_d = TxWait;
                 else tx_cnt_d = tx_cnt_q - 18'd1;
         TxWait: if (!uart_wa) tx_state_d = TxIdle;
         default: tx_state_d = TxIdle;
      endcase
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      case (rx_state_q)
         RxIdle: if (rx_req) begin
            rx_state_d = RxAck;
            rx_cnt_d   = hold;
         end
         RxAck: if (rx_cnt_q == 18'd1) rx_state_d = RxIdle;
                else rx_cnt_d = rx_cnt_q - 18'd1;
         default: rx_state_d = RxIdle;
      endcase
   end

   always_comb begin
      uart_we = (tx_state_q == TxLoad);
      uart_re = (rx_state_q == RxAck);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tx_wptr_q   <= '0;
         tx_rptr_q   <= '0;
         rx_wptr_q   <= '0;
         rx_rptr_q   <= '0;
         tx_byte_q   <= '0;
         bus_rdata_q <= '0;
         overrun_q   <= 1'b0;
      end else begin
         if (tx_push) tx_wptr_q <= tx_wptr_q + PtrW'(1);
         if (tx_pop) begin
            tx_rptr_q <= tx_rptr_q + PtrW'(1);
            tx_byte_q <= tx_mem[tx_rptr_q[PtrW-2:0]];
         end
         if (rx_push) rx_wptr_q <= rx_wptr_q + PtrW'(1);
         if (rx_pop)  rx_rptr_q <= rx_rptr_q + PtrW'(1);
         if (ovr_set)      overrun_q <= 1'b1;
         else if (ovr_clr) overrun_q <= 1'b0;
         if (bus_re) begin
            if (bus_addr)      bus_rdata_q <= status;
            else if (rx_empty) bus_rdata_q <= 32'hFFFF_FFFF;
            else               bus_rdata_q <= {24'b0, rx_mem[rx_rptr_q[PtrW-2:0]]};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (tx_push) tx_mem[tx_wptr_q[PtrW-2:0]] <= bus_wdata[7:0];
      if (rx_push) rx_mem[rx_wptr_q[PtrW-2:0]] <= uart_si[7:0];
   end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed-plus-random bench for uart_fifo against a queue-based model of both FIFOs.
module tb_uart_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] clkdiv;
   logic        bus_addr, bus_re, bus_we;
   logic [31:0] bus_wdata, bus_rdata;
   logic        irq, uart_we, uart_re, uart_wa;
   logic [31:0] uart_so, uart_si;

   always #5 clk = ~clk;

   uart_fifo #(.DEPTH_LOG2(4)) dut (
      .clk(clk), .rst_n(rst_n), .clkdiv(clkdiv),
      .bus_addr(bus_addr), .bus_re(bus_re), .bus_we(bus_we),
      .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .irq(irq),
      .uart_we(uart_we), .uart_re(uart_re), .uart_so(uart_so),
      .uart_si(uart_si), .uart_wa(uart_wa)
   );

   int n_vec = 0;
   int n_err = 0;
   byte unsigned tx_q[$];
   byte unsigned rx_q[$];
   bit ovr = 1'b0;
   logic [31:0] rd;
   byte unsigned b;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic int hlen();
      return int'(clkdiv[16:0]) + 1;
   endfunction

   function automatic logic [31:0] exp_status();
      return {27'b0, ovr, rx_q.size() == 16, rx_q.size() == 0, tx_q.size() == 0,
              tx_q.size() == 16};
   endfunction

   task automatic bus_write(input logic addr, input logic [31:0] data);
      bus_addr = addr; bus_wdata = data; bus_we = 1'b1;
      tick;
      bus_we = 1'b0;
   endtask

   task automatic bus_read(input logic addr, output logic [31:0] data);
      bus_addr = addr; bus_re = 1'b1;
      tick;
      bus_re = 1'b0;
      data = bus_rdata;
   endtask

   task automatic tx_write(input byte unsigned v);
      bus_write(1'b0, {24'b0, v});
      if (tx_q.size() < 16) tx_q.push_back(v);
   endtask

   task automatic chk_status(input string tag);
      logic [31:0] s;
      bus_read(1'b1, s);
      chk(tag, s, exp_status());
   endtask

   task automatic read_data(input string tag);
      logic [31:0] d, e;
      bus_read(1'b0, d);
      e = (rx_q.size() != 0) ? {24'b0, rx_q.pop_front()} : 32'hFFFF_FFFF;
      chk(tag, d, e);
   endtask

   // Acts as the UART: raises wa once a frame starts and holds it a random while.
   task automatic tx_frame(input string tag);
      int w = 0, n = 0, bad = 0, extra = 0, k;
      logic [31:0] e;
      while (!uart_we && w < 200) begin tick; w++; end
      chk({tag, " we_start"}, uart_we, 1);
      e = (tx_q.size() != 0) ? {24'b0, tx_q.pop_front()} : 32'hDEAD_BEEF;
      chk({tag, " so"}, uart_so, e);
      uart_wa = 1'b1;
      while (uart_we && n < 300) begin
         if (uart_so !== e) bad++;
         n++;
         tick;
      end
      chk({tag, " we_len"}, n, hlen());
      chk({tag, " so_stable"}, bad, 0);
      k = $urandom_range(2, 8);
      for (int i = 0; i < k; i++) begin
         if (uart_we) extra++;
         tick;
      end
      chk({tag, " we_while_wa"}, extra, 0);
      uart_wa = 1'b0;
   endtask

   task automatic rx_push(input string tag, input byte unsigned v);
      int w = 0, n = 0;
      uart_si = {24'b0, v};
      while (!uart_re && w < 50) begin tick; w++; end
      chk({tag, " re_start"}, uart_re, 1);
      uart_si = 32'hFFFF_FFFF;
      while (uart_re && n < 300) begin n++; tick; end
      chk({tag, " re_len"}, n, hlen());
      if (rx_q.size() == 16) ovr = 1'b1;
      else rx_q.push_back(v);
   endtask

   initial begin
      rst_n = 1'b0; clkdiv = 32'd3; bus_addr = 1'b0; bus_re = 1'b0; bus_we = 1'b0;
      bus_wdata = '0; uart_si = 32'hFFFF_FFFF; uart_wa = 1'b0;
      tick; tick;
      rst_n = 1'b1;
      chk("rst rdata", bus_rdata, 32'h0);
      chk("rst we", uart_we, 0);
      chk("rst re", uart_re, 0);
      chk("rst so", uart_so, 32'h0);
      chk("rst irq", irq, 0);
      chk_status("rst status");

      // TX drain with H = 4 and the two-cycle first-byte latency
      clkdiv = 32'd3;
      tx_write(8'h41);
      chk("tx latency early", uart_we, 0);
      tx_write(8'h42);
      chk("tx latency", uart_we, 1);
      tx_frame("tx41");
      tx_frame("tx42");
      chk_status("tx drained");

      // TX full while the UART is busy
      clkdiv = $urandom_range(0, 4);
      uart_wa = 1'b1;
      for (int i = 0; i < 17; i++) tx_write(8'($urandom));
      chk_status("tx full status");
      uart_wa = 1'b0;
      for (int i = 0; i < 16; i++) tx_frame("txfull");
      begin
         int extra = 0;
         for (int i = 0; i < 3 * hlen() + 10; i++) begin
            if (uart_we) extra++;
            tick;
         end
         chk("tx 17th dropped", extra, 0);
      end
      chk_status("tx full drained");

      // RX single byte
      clkdiv = $urandom_range(0, 6);
      rx_push("rx5a", 8'h5A);
      chk("rx irq set", irq, 1);
      read_data("rx read 5a");
      read_data("rx read empty");
      chk("rx irq clr", irq, 0);

      // RX overrun then clear, then drain in order
      for (int i = 0; i < 17; i++) rx_push("rxovr", 8'($urandom));
      chk_status("ovr status");
      chk("ovr irq", irq, 1);
      bus_write(1'b1, 32'h10);
      ovr = 1'b0;
      chk_status("ovr cleared");
      for (int i = 0; i < 16; i++) read_data("ovr drain");
      chk_status("ovr drained");

      // Bus pop coincides with an RX push into a full FIFO
      clkdiv = $urandom_range(0, 6);
      for (int i = 0; i < 16; i++) rx_push("simfill", 8'($urandom));
      b = 8'($urandom);
      uart_si = {24'b0, b};
      bus_addr = 1'b0; bus_re = 1'b1;
      tick;
      bus_re = 1'b0;
      rd = bus_rdata;
      chk("sim read oldest", rd, {24'b0, rx_q.pop_front()});
      chk("sim re", uart_re, 1);
      ovr = 1'b1;
      uart_si = 32'hFFFF_FFFF;
      begin
         int w = 0;
         while (uart_re && w < 300) begin tick; w++; end
         chk("sim re done", uart_re, 0);
      end
      chk_status("sim status");
      for (int i = 0; i < 15; i++) read_data("sim drain");
      read_data("sim empty");

      // Reset in the middle of a TX frame
      clkdiv = 32'd7;
      tx_write(8'hC3);
      tick;
      chk("midrst we", uart_we, 1);
      tick;
      rst_n = 1'b0;
      tick;
      chk("midrst we drop", uart_we, 0);
      rst_n = 1'b1;
      tx_q.delete(); rx_q.delete(); ovr = 1'b0;
      chk("midrst irq", irq, 0);
      chk_status("midrst status");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
